hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, halt drain
module hazard_ctrl #(
  parameter logic [5:0] HALT_OP   = 6'b010001,
  parameter int         DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  output logic        hazard,
  output logic        ifid_hold,
  output logic        idex_bubble,
  output logic        flush_ifid,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int CLOG = $clog2(DRAIN_CYC + 1);
  localparam int CW   = (CLOG < 2) ? 2 : CLOG;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t        state, state_n;
  logic [CW-1:0] drain_cnt, drain_cnt_n;
  logic          stall_inc, flush_inc;
  logic          load_use;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       unused_imm;

  assign opcode     = id_inst[31:26];
  assign rs         = id_inst[25:21];
  assign rt         = id_inst[20:16];
  assign unused_imm = ^id_inst[15:0];

  // Load in EX whose destination feeds ID; r0 is never a real dependency
  assign load_use = ex_valid & ex_is_load & id_valid & (ex_rd != 5'd0) &
                    ((ex_rd == rs) | (ex_rd == rt));

  // Next-state and control decode; reset forces every control output low
  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    hazard      = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      RUN: begin
        if (br_taken) begin
          flush_ifid  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          hazard      = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (id_valid && (opcode == HALT_OP)) begin
          // The halt itself moves on into EX while fetch freezes
          hazard      = 1'b1;
          ifid_hold   = 1'b1;
          state_n     = DRAIN;
          drain_cnt_n = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        hazard      = 1'b1;
        flush_ifid  = 1'b1;
        idex_bubble = 1'b1;
        if (drain_cnt <= CNT_ONE) begin
          state_n     = HALTED;
          drain_cnt_n = '0;
        end else begin
          drain_cnt_n = drain_cnt - CNT_ONE;
        end
      end
      HALTED: begin
        hazard      = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        state_n     = RUN;
        drain_cnt_n = '0;
      end
    endcase
    if (rst) begin
      hazard      = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b0;
      flush_ifid  = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  // State, drain counter, halted flag and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      halted    <= (state_n == HALTED);
      if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_inc && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with randomized and directed stimulus
module tb_hazard_ctrl;

  localparam logic [5:0] HALT = 6'b010001;
  localparam int         DCYC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst;
  logic        id_valid, ex_valid, ex_is_load, br_taken;
  logic [4:0]  ex_rd;
  logic        hazard, ifid_hold, idex_bubble, flush_ifid, halted;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.HALT_OP(HALT), .DRAIN_CYC(DCYC)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .br_taken(br_taken), .hazard(hazard), .ifid_hold(ifid_hold),
    .idex_bubble(idex_bubble), .flush_ifid(flush_ifid), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    bit       chk_regs;
    bit       hazard, hold, bubble, flush, halted;
    int       stall, flushes;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: cycles elapsed since the halt was accepted (-1 = none)
  int m_since = -1;
  int m_stall = 0;
  int m_flush = 0;
  bit m_known = 0;

  task automatic drive(input bit r, input logic [31:0] inst, input bit idv,
                       input bit exv, input bit exl, input logic [4:0] rd, input bit br);
    exp_t e;
    bit   lu, is_halt_state, is_drain;
    @(posedge clk);
    #1;
    rst = r; id_inst = inst; id_valid = idv; ex_valid = exv;
    ex_is_load = exl; ex_rd = rd; br_taken = br;
    lu = exv && exl && idv && (rd != 0) && (rd == inst[25:21] || rd == inst[20:16]);
    is_drain      = (m_since >= 1) && (m_since <= DCYC);
    is_halt_state = (m_since > DCYC);
    e = '{chk_regs: m_known, hazard: 0, hold: 0, bubble: 0, flush: 0,
          halted: is_halt_state, stall: m_stall, flushes: m_flush};
    if (r) begin
      m_since = -1; m_stall = 0; m_flush = 0; m_known = 1;
    end else if (is_halt_state) begin
      e.hazard = 1; e.hold = 1; e.bubble = 1;
    end else if (is_drain) begin
      e.hazard = 1; e.flush = 1; e.bubble = 1;
      m_since++;
    end else if (br) begin
      e.flush = 1; e.bubble = 1;
      if (m_flush < 65535) m_flush++;
    end else if (lu) begin
      e.hazard = 1; e.hold = 1; e.bubble = 1;
      if (m_stall < 65535) m_stall++;
    end else if (idv && inst[31:26] == HALT) begin
      e.hazard = 1; e.hold = 1;
      m_since = 1;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: pop one expected response per presented cycle and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hazard",      int'(hazard),      int'(e.hazard));
        chk("ifid_hold",   int'(ifid_hold),   int'(e.hold));
        chk("idex_bubble", int'(idex_bubble), int'(e.bubble));
        chk("flush_ifid",  int'(flush_ifid),  int'(e.flush));
        if (e.chk_regs) begin
          chk("halted",    int'(halted),    int'(e.halted));
          chk("stall_cnt", int'(stall_cnt), e.stall);
          chk("flush_cnt", int'(flush_cnt), e.flushes);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    logic [5:0] op;
    rst = 1; id_inst = 0; id_valid = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; br_taken = 0;
    drive(1, 32'd0, 0, 0, 0, 0, 0);
    drive(1, 32'd0, 1, 1, 1, 5'd5, 1);
    drive(0, 32'd0, 0, 0, 0, 0, 0);
    // Load-use on rs, then on rt
    drive(0, mk(6'd0, 5'd5, 5'd9), 1, 1, 1, 5'd5, 0);
    drive(0, mk(6'd0, 5'd7, 5'd5), 1, 1, 1, 5'd5, 0);
    // r0 destination never stalls
    drive(0, mk(6'd0, 5'd0, 5'd0), 1, 1, 1, 5'd0, 0);
    // Non-load or bubble in ID: no stall
    drive(0, mk(6'd0, 5'd5, 5'd5), 1, 1, 0, 5'd5, 0);
    drive(0, mk(6'd0, 5'd5, 5'd5), 0, 1, 1, 5'd5, 0);
    // Branch wins over load-use and over halt
    drive(0, mk(6'd0, 5'd5, 5'd1), 1, 1, 1, 5'd5, 1);
    drive(0, mk(HALT, 5'd1, 5'd2), 1, 0, 0, 5'd0, 1);
    // Load-use wins over halt opcode
    drive(0, mk(HALT, 5'd3, 5'd2), 1, 1, 1, 5'd3, 0);
    // Halt with bubble in ID ignored, then real halt, drain, hold halted
    drive(0, mk(HALT, 5'd1, 5'd2), 0, 0, 0, 5'd0, 0);
    drive(0, mk(HALT, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0);
    for (int i = 0; i < 8; i++)
      drive(0, mk(6'($urandom), 5'd4, 5'd4), 1, 1, 1, 5'd4, 1'($urandom));
    // Reset out of HALTED, and a reset landing mid-drain
    drive(1, mk(6'd0, 5'd4, 5'd4), 1, 1, 1, 5'd4, 1);
    drive(0, 32'd0, 0, 0, 0, 0, 0);
    drive(0, mk(HALT, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0);
    drive(0, 32'd0, 0, 0, 0, 0, 0);
    drive(1, 32'd0, 0, 0, 0, 0, 0);
    drive(0, mk(6'd0, 5'd2, 5'd2), 1, 1, 1, 5'd2, 0);
    // Randomized traffic with a small register pool to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      op = ($urandom_range(0, 29) == 0) ? HALT : 6'($urandom);
      drive($urandom_range(0, 59) == 0,
            mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end
    // Saturation of the stall counter: 65535 stalls then extra ones
    drive(1, 32'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65538; i++)
      drive(0, mk(6'd0, 5'd5, 5'd6), 1, 1, 1, 5'd5, 0);
    drive(0, 32'd0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
